// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed multiplier among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int OP_W    = 32,
  parameter int PROD_W  = 67,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_x,
  input  logic [NREQ*OP_W-1:0] req_y,
  output logic                 mul_start,
  output logic [OP_W-1:0]      mul_x,
  output logic [OP_W-1:0]      mul_y,
  input  logic                 mul_done,
  input  logic [PROD_W-1:0]    mul_product,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [PROD_W-1:0]    rsp_product,
  output logic                 rsp_err,
  output logic                 busy
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("mul_share_arbiter: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_t;

  state_t              state_reg, state_next;
  logic [IDW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [OP_W-1:0]     mul_x_reg, mul_x_next;
  logic [OP_W-1:0]     mul_y_reg, mul_y_next;
  logic [IDW-1:0]      rsp_id_reg, rsp_id_next;
  logic [PROD_W-1:0]   rsp_product_reg, rsp_product_next;

  logic [OP_W-1:0]     x_arr [NREQ];
  logic [OP_W-1:0]     y_arr [NREQ];

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*OP_W +: OP_W];
    assign y_arr[gi] = req_y[gi*OP_W +: OP_W];
  end

  // Rotating priority: search starts just after the last requester served.
  logic           grant_found;
  logic [IDW-1:0] grant_id;

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  logic [7:0] wdog_reg, wdog_next;
  logic       rsp_err_reg, rsp_err_next;
`endif

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    mul_x_next       = mul_x_reg;
    mul_y_next       = mul_y_reg;
    rsp_id_next      = rsp_id_reg;
    rsp_product_next = rsp_product_reg;
`ifdef MUL_ARB_TIMEOUT_EN
    wdog_next        = wdog_reg;
    rsp_err_next     = rsp_err_reg;
`endif
    unique case (state_reg)
      S_IDLE: begin
        if (grant_found) begin
          mul_x_next  = x_arr[grant_id];
          mul_y_next  = y_arr[grant_id];
          rsp_id_next = grant_id;
          state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MUL_ARB_TIMEOUT_EN
        wdog_next  = '0;
`endif
        state_next = S_WAIT;
      end
      S_WAIT: begin
`ifdef MUL_ARB_TIMEOUT_EN
        wdog_next = wdog_reg + 8'd1;
`endif
        if (mul_done) begin
          rsp_product_next = mul_product;
          state_next       = S_RESP;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        // Fires on the TIMEOUT-th WAIT cycle, so RESP starts TIMEOUT cycles after WAIT entry.
        else if (wdog_next == 8'(TIMEOUT)) begin
          rsp_product_next = '0;
          rsp_err_next     = 1'b1;
          state_next       = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_next  = rsp_id_reg;
`ifdef MUL_ARB_TIMEOUT_EN
          rsp_err_next = 1'b0;
`endif
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg       <= S_IDLE;
      rr_ptr_reg      <= IDW'(NREQ - 1);
      mul_x_reg       <= '0;
      mul_y_reg       <= '0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      mul_x_reg       <= mul_x_next;
      mul_y_reg       <= mul_y_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_product_reg <= rsp_product_next;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wdog_reg    <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      wdog_reg    <= wdog_next;
      rsp_err_reg <= rsp_err_next;
    end
  end
  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  assign mul_start   = (state_reg == S_ISSUE);
  assign rsp_valid   = (state_reg == S_RESP);
  assign busy        = (state_reg != S_IDLE);
  assign mul_x       = mul_x_reg;
  assign mul_y       = mul_y_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_product = rsp_product_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter; the bench plays the multiplier.
// Define MUL_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_mul_share_arbiter;
  localparam int NREQ = 4, OP_W = 32, PROD_W = 67, IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_b = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_x = '0;
  logic [NREQ*OP_W-1:0] req_y = '0;
  logic                 mul_start;
  logic [OP_W-1:0]      mul_x, mul_y;
  logic                 mul_done = 1'b0;
  logic [PROD_W-1:0]    mul_product = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [PROD_W-1:0]    rsp_product;
  logic                 rsp_err;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  mul_share_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .PROD_W(PROD_W), .IDW(IDW), .TIMEOUT(20)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [31:0] x, input logic [31:0] y);
    req_x[id*OP_W +: OP_W] = x;
    req_y[id*OP_W +: OP_W] = y;
  endtask

  // One full transaction; caller has already driven req_valid and operands after a negedge.
  task automatic run_op(input int id_exp, input logic [66:0] prod_exp, input int lat,
                        input int stall, input bit hold);
    logic signed [66:0] p;
    logic [NREQ-1:0]    saved;
    logic [66:0]        held;
    #1;
    check("grant_onehot", 128'(req_ready), 128'(4'b0001 << id_exp));
    check("idle_busy", 128'(busy), 128'(1'b0));
    @(negedge clk);
    if (!hold) req_valid = '0;
    // done during ISSUE must be ignored
    mul_done = 1'b1;
    mul_product = 67'h1234;
    #1;
    check("issue_start", 128'(mul_start), 128'(1'b1));
    check("issue_ready0", 128'(req_ready), 128'(0));
    check("issue_x", 128'(mul_x), 128'(req_x[id_exp*OP_W +: OP_W]));
    check("issue_y", 128'(mul_y), 128'(req_y[id_exp*OP_W +: OP_W]));
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    check("wait_start0", 128'(mul_start), 128'(1'b0));
    check("wait_no_rsp", 128'(rsp_valid), 128'(1'b0));
    for (int i = 1; i < lat; i++) @(negedge clk);
    p = $signed(mul_x) * $signed(mul_y);
    mul_done = 1'b1;
    mul_product = p;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    check("rsp_valid", 128'(rsp_valid), 128'(1'b1));
    check("rsp_id", 128'(rsp_id), 128'(id_exp));
    check("rsp_product", 128'(rsp_product), 128'(prod_exp));
    check("rsp_err", 128'(rsp_err), 128'(1'b0));
    saved = req_valid;
    held  = rsp_product;
    for (int s = 0; s < stall; s++) begin
      req_valid = '1;
      mul_done = (s == 3);
      mul_product = 67'h5555;
      @(negedge clk);
      mul_done = 1'b0;
      #1;
      check("bp_valid", 128'(rsp_valid), 128'(1'b1));
      check("bp_id", 128'(rsp_id), 128'(id_exp));
      check("bp_product", 128'(rsp_product), 128'(prod_exp));
      check("bp_ready0", 128'(req_ready), 128'(0));
    end
    req_valid = saved;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("txn: id=%0d product=%0h latency=%0d stall=%0d", id_exp, held, lat, stall);
    check("post_rsp_valid", 128'(rsp_valid), 128'(1'b0));
  endtask

  logic [66:0] cont_prod [4];

  initial begin
    cont_prod[0] = 67'd10;
    cont_prod[1] = 67'd40;
    cont_prod[2] = 67'd90;
    cont_prod[3] = 67'd160;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_start", 128'(mul_start), 128'(0));
    check("rst_mul_x", 128'(mul_x), 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    rst_b = 1'b1;
    @(negedge clk);

    // single op on requester 0
    set_ops(0, 32'd2, 32'd3);
    req_valid = 4'b0001;
    run_op(0, 67'd6, 1, 0, 1'b0);

    // signed op on requester 2
    set_ops(2, -32'sd5, 32'sd7);
    req_valid = 4'b0100;
    run_op(2, 67'h7_FFFF_FFFF_FFFF_FFDD, 2, 0, 1'b0);

    // backpressure on requester 1 with a stray done during RESP
    set_ops(1, 32'd100, -32'sd3);
    req_valid = 4'b0010;
    run_op(1, 67'h7_FFFF_FFFF_FFFF_FED4, 3, 10, 1'b0);

    // reset during WAIT, then a late done
    set_ops(3, 32'd1, 32'd1);
    req_valid = 4'b1000;
    #1;
    check("r5_grant", 128'(req_ready), 128'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("r5_busy", 128'(busy), 128'(0));
    check("r5_rsp_valid", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    rst_b = 1'b1;
    mul_done = 1'b1;
    mul_product = 67'd1;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    check("r5_late_busy", 128'(busy), 128'(0));
    check("r5_late_rsp", 128'(rsp_valid), 128'(0));
    @(negedge clk);

    // contention: all four hold valid, expect rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'(10 * (i + 1)));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) run_op(i % 4, cont_prod[i % 4], 1 + (i % 3), 0, 1'b1);
    req_valid = '0;
    @(negedge clk);

`ifdef MUL_ARB_TIMEOUT_EN
    begin
      int cnt;
      set_ops(1, 32'd9, 32'd9);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      cnt = 0;
      #1;
      while (!rsp_valid && cnt < 100) begin
        @(negedge clk);
        #1;
        cnt++;
      end
      check("wd_cycles", 128'(cnt), 128'(20));
      check("wd_err", 128'(rsp_err), 128'(1));
      check("wd_product", 128'(rsp_product), 128'(0));
      check("wd_id", 128'(rsp_id), 128'(1));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      $display("txn: id=1 watchdog abort after %0d cycles", cnt);
      check("wd_err_clr", 128'(rsp_err), 128'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
